write_buffer: RTL
=================

// Module: write_buffer
// PURPOSE
//  Posted-write FIFO between the Cache refill/writeback port (dbOut_*) and main memory.
//  - Cache writes are absorbed in one cycle and drained to memory in the background.
//  - Reads are strictly ordered after all earlier buffered writes.
//  - Upstream side presents a memory-like bus to the Cache; downstream side drives the memory bus.
// PARAMETERS
//  DEPTH_LOG2  2   log2 of FIFO entries (default 4 entries)
//  ADDR_WIDTH  32  byte address width
//  DATA_WIDTH  32  data word width
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  res          in   1   asynchronous reset, active-low (0 = reset)
//  db_re        in   1   read request from Cache, held until accepted
//  db_we        in   1   write request from Cache, held until accepted
//  db_addr      in   32  request byte address; bits [1:0] ignored
//  db_dataOut   in   32  write data from Cache
//  db_dataIn    out  32  read data to Cache, registered
//  db_ready     out  1   request accept / read-complete indicator
//  mem_re       out  1   read request to memory
//  mem_we       out  1   write request to memory
//  mem_addr     out  32  word address to memory, bits [1:0] = 0
//  mem_dataOut  out  32  write data to memory
//  mem_dataIn   in   32  memory read data, valid the cycle after mem_re is accepted
//  mem_ready    in   1   memory accepts mem_re/mem_we this cycle
// BEHAVIOUR
//  - Reset (res=0): FIFO emptied, pointers/count 0, state IDLE, db_dataIn=0, mem_re=mem_we=0.
//    Reset mid-drain discards all pending writes.
//  - db_ready = (state==IDLE) && !full.
//  - Write accept: db_we && db_ready; push {db_addr[31:2],2'b0, db_dataOut}.
//  - Read accept: db_re && !db_we && db_ready; db_we wins if both are high.
//  - Drain: mem_we = !empty && state!=READ_REQ && state!=READ_WAIT.
//    mem_addr/mem_dataOut come from the FIFO head; pop when mem_we && mem_ready.
//    An entry pushed at edge T is first offered on mem_we in cycle T+1.
//  - Push and pop in the same cycle: count unchanged. Pointers wrap modulo 2^DEPTH_LOG2.
//    full = (count == 2^DEPTH_LOG2).
//  - FSM:
//    IDLE      on read accept: latch address; -> READ_REQ if FIFO empty (or emptying this cycle), else -> DRAIN.
//    DRAIN     keep draining; -> READ_REQ once count==0.
//    READ_REQ  mem_re=1, mem_addr=latched address; -> READ_WAIT on mem_ready.
//    READ_WAIT capture mem_dataIn into db_dataIn; -> IDLE.
//  - Read latency with empty FIFO and mem_ready=1: accept at T, mem_re in T+1, data captured at end of T+2,
//    db_ready high in T+3 with db_dataIn valid.
//  - db_dataIn holds its value until the next read completes.
//  - No write is accepted while a read is outstanding (db_ready=0 in DRAIN/READ_REQ/READ_WAIT).
//  - mem_re and mem_we are never high in the same cycle.
// CONFIGURATION
//  WB_FORWARD_EN defined:
//    - On read accept in IDLE, compare the word address against all valid FIFO entries (including one popping this cycle).
//    - On a hit: youngest matching entry's data loaded into db_dataIn at the accept edge; state stays IDLE.
//      No drain, no mem_re; data is valid the cycle after accept.
//    - On a miss: normal path.
//  WB_FORWARD_EN undefined: no comparators; every read drains then issues mem_re.
// TESTING (memory model: mem_ready=1, read data valid one cycle after mem_re)
//  1. Reset with res=0 mid-traffic -> all outputs 0, db_ready=1 after release, pending writes never reach memory.
//  2. Write 0xBADC0DE @0x000, then 0xDEADBEEF @0x100 on back-to-back cycles -> two mem_we cycles in order;
//     memory holds both values.
//  3. Hold mem_ready=0; issue 4 writes -> db_ready=0 after the 4th.
//     Release mem_ready -> 4 pops in FIFO order, db_ready=1 after the first pop.
//  4. Write 0x11111111 @0x200, then read @0x200 (no forward):
//     - mem_we @0x200 precedes mem_re.
//     - db_dataIn=0x11111111 when db_ready returns.
//  5. Read @0x103 with empty FIFO -> mem_addr=0x100, 3-cycle latency, db_dataIn equals the memory word at 0x100.
//  6. WB_FORWARD_EN: with mem_ready=0, write 0xA @0x40 then 0xB @0x40, then read @0x40 ->
//     db_dataIn=0xB one cycle after accept, mem_re never asserted.

Source files
------------

// File: rtl/write_buffer.sv
// rtl/write_buffer.sv - posted-write FIFO between the Cache dbOut port and main memory
// Optional read-after-write forwarding from the FIFO is enabled with `define WB_FORWARD_EN.
module write_buffer #(
    parameter int DEPTH_LOG2 = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  db_re,
    input  logic                  db_we,
    input  logic [ADDR_WIDTH-1:0] db_addr,
    input  logic [DATA_WIDTH-1:0] db_dataOut,
    output logic [DATA_WIDTH-1:0] db_dataIn,
    output logic                  db_ready,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_dataOut,
    input  logic [DATA_WIDTH-1:0] mem_dataIn,
    input  logic                  mem_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] C_ONE  = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_READ_REQ,
        S_READ_WAIT
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_fifo_addr [DEPTH];
    logic [DATA_WIDTH-1:0]   r_fifo_data [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_count;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [DATA_WIDTH-1:0]   r_db_data;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_db_ready;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_rd_acc;
    logic                    w_mem_we;
    logic                    w_empty_now;
    logic [ADDR_WIDTH-1:0]   w_req_addr;

    assign w_full      = (r_count == C_FULL);
    assign w_empty     = (r_count == '0);
    assign w_db_ready  = (r_state == S_IDLE) && !w_full;
    assign w_push      = db_we && w_db_ready;
    assign w_rd_acc    = db_re && !db_we && w_db_ready;
    assign w_mem_we    = !w_empty && (r_state != S_READ_REQ) && (r_state != S_READ_WAIT);
    assign w_pop       = w_mem_we && mem_ready;
    assign w_empty_now = w_empty || ((r_count == C_ONE) && w_pop);
    assign w_req_addr  = db_addr & ~ADDR_WIDTH'(3);

`ifdef WB_FORWARD_EN
    logic                  w_fwd_hit;
    logic [DATA_WIDTH-1:0] w_fwd_data;
    logic [DEPTH_LOG2-1:0] w_idx;

    // Walk oldest to youngest so the last match is the youngest write to that word.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + DEPTH_LOG2'(i);
            if (((DEPTH_LOG2 + 1)'(i) < r_count) && (r_fifo_addr[w_idx] == w_req_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_fifo_data[w_idx];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= w_req_addr;
            r_fifo_data[r_wr_ptr] <= db_dataOut;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state   <= S_IDLE;
            r_rd_addr <= '0;
            r_db_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rd_acc) begin
                        r_rd_addr <= w_req_addr;
`ifdef WB_FORWARD_EN
                        if (w_fwd_hit)
                            r_db_data <= w_fwd_data;
                        else
`endif
                        if (w_empty_now)
                            r_state <= S_READ_REQ;
                        else
                            r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_empty) r_state <= S_READ_REQ;
                end
                S_READ_REQ: begin
                    if (mem_ready) r_state <= S_READ_WAIT;
                end
                S_READ_WAIT: begin
                    r_db_data <= mem_dataIn;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Address/data lines are held at zero whenever no memory request is active.
    assign db_dataIn   = r_db_data;
    assign db_ready    = w_db_ready;
    assign mem_re      = (r_state == S_READ_REQ);
    assign mem_we      = w_mem_we;
    assign mem_addr    = (r_state == S_READ_REQ) ? r_rd_addr :
                         (w_mem_we ? r_fifo_addr[r_rd_ptr] : '0);
    assign mem_dataOut = w_mem_we ? r_fifo_data[r_rd_ptr] : '0;

endmodule
